// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and requester indices for the round-robin bus arbiter.
package bus_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANTED, BUSY, RELEASE} arb_state_e;
  localparam int REQ_FETCH_VAPA  = 0;
  localparam int REQ_FETCH_ADDR  = 1;
  localparam int REQ_FETCH_STORE = 2;
  localparam int REQ_MM_VAPA     = 3;
  localparam int REQ_MM_ADDR     = 4;
  localparam int REQ_MM_STORE    = 5;
  localparam logic [5:0] HIPRI_MASK_DEFAULT = 6'b111000;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: first set request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N = 6,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);
  localparam logic [W:0] NL = (W+1)'(N);
  logic [N-1:0] rot;
  logic [W-1:0] pos [N];
  logic [W:0] s;
  always_comb begin
    rot = '0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = {1'b0, ptr_i} + (W+1)'(i);
      s = s >= NL ? s - NL : s;
      pos[i] = s[W-1:0];
      rot[i] = req_i[s[W-1:0]];
    end
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) idx_o = pos[i];
    found_o = |rot;
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: one-at-a-time shared-bus grant with a turnaround cycle after each release,
// round-robin within class and mm requesters ahead of fetch.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 6,
  parameter logic [NREQ-1:0] HIPRI_MASK = NREQ'(HIPRI_MASK_DEFAULT),
  parameter int GRANT_TIMEOUT = 16,
  parameter int OWNER_W = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    in_reqcyc,
  input  logic [NREQ-1:0]    in_busy,
  output logic [NREQ-1:0]    out_grant,
  output logic [OWNER_W-1:0] out_owner,
  output logic               out_grant_valid,
  output logic               out_bus_busy,
  output logic               out_timeout_err,
  output logic               out_protocol_err
);
  localparam logic [7:0] WAIT_MAX = 8'(GRANT_TIMEOUT - 1);
  localparam logic [OWNER_W-1:0] LAST = OWNER_W'(NREQ - 1);
  arb_state_e state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d, cand;
  logic [OWNER_W-1:0] owner_q, owner_d, ptr_q, ptr_d, win;
  logic [7:0] wait_q, wait_d;
  logic tout_q, tout_d, perr_q, perr_d, found, own_busy, own_req, rel;
  assign cand = |(in_reqcyc & HIPRI_MASK) ? in_reqcyc & HIPRI_MASK : in_reqcyc;
  rr_pick #(.N(NREQ), .W(OWNER_W)) u_pick (
    .req_i  (cand),
    .ptr_i  (ptr_q),
    .idx_o  (win),
    .found_o(found)
  );
  assign own_busy = in_busy[owner_q];
  assign own_req  = in_reqcyc[owner_q];
  // busy outranks abandon, which outranks timeout
  assign rel = (state_q == BUSY && !own_busy) ||
               (state_q == GRANTED && !own_busy && (!own_req || wait_q == WAIT_MAX));
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    tout_d  = state_q == GRANTED && rel && own_req;
    perr_d  = |(in_busy & ~grant_q);
    if (rel) begin
      state_d = RELEASE;
      grant_d = '0;
      ptr_d   = owner_q == LAST ? '0 : owner_q + 1'b1;
    end else if (state_q == IDLE && found) begin
      state_d = GRANTED;
      grant_d = NREQ'(1) << win;
      owner_d = win;
      wait_d  = '0;
    end else if (state_q == GRANTED) begin
      state_d = own_busy ? BUSY : GRANTED;
      wait_d  = wait_q + 1'b1;
    end else if (state_q == RELEASE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      wait_q  <= '0;
      tout_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      tout_q  <= tout_d;
      perr_q  <= perr_d;
    end
  end
  assign out_grant        = grant_q;
  assign out_owner        = owner_q;
  assign out_grant_valid  = |grant_q;
  assign out_bus_busy     = |in_busy;
  assign out_timeout_err  = tout_q;
  assign out_protocol_err = perr_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scenarios plus random traffic against a transaction-level model.
module tb_bus_arbiter_rr;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] in_reqcyc = '0, in_busy = '0;
  logic [5:0] out_grant;
  logic [2:0] out_owner;
  logic out_grant_valid, out_bus_busy, out_timeout_err, out_protocol_err;
  int total = 0, bad = 0;
  int m_owner = -1, m_last = 0, m_ptr = 0, m_age = 0;
  bit m_inbusy = 0, m_cool = 0, m_tout = 0, m_perr = 0;

  bus_arbiter_rr dut (
    .clk(clk), .reset(reset), .in_reqcyc(in_reqcyc), .in_busy(in_busy),
    .out_grant(out_grant), .out_owner(out_owner), .out_grant_valid(out_grant_valid),
    .out_bus_busy(out_bus_busy), .out_timeout_err(out_timeout_err),
    .out_protocol_err(out_protocol_err)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [5:0] rq, int ptr);
    logic [5:0] c;
    c = (rq & 6'b111000) != 0 ? rq & 6'b111000 : rq;
    for (int k = 0; k < 6; k++)
      if (c[(ptr + k) % 6]) return (ptr + k) % 6;
    return -1;
  endfunction

  function automatic logic [5:0] m_grant();
    logic [5:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_grant(), m_owner >= 0, 3'(m_last), m_tout, m_perr, |in_busy};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {out_grant, out_grant_valid, out_owner, out_timeout_err, out_protocol_err, out_bus_busy};
  endfunction

  task automatic m_release();
    m_ptr = (m_owner + 1) % 6;
    m_owner = -1;
    m_cool = 1;
  endtask

  // one clock edge of the specified behaviour, using the inputs currently driven
  task automatic model_edge();
    int w;
    m_perr = |(in_busy & ~m_grant());
    m_tout = 0;
    if (reset) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_age = 0; m_inbusy = 0; m_cool = 0; m_perr = 0;
    end else if (m_owner < 0) begin
      if (m_cool) m_cool = 0;
      else begin
        w = pick(in_reqcyc, m_ptr);
        if (w >= 0) begin m_owner = w; m_last = w; m_age = 0; m_inbusy = 0; end
      end
    end else if (m_inbusy) begin
      if (!in_busy[m_owner]) m_release();
    end else if (in_busy[m_owner]) m_inbusy = 1;
    else if (!in_reqcyc[m_owner]) m_release();
    else if (m_age == TO - 1) begin m_tout = 1; m_release(); end
    else m_age++;
  endtask

  task automatic step(input logic r, input logic [5:0] rq, input logic [5:0] bz);
    reset = r; in_reqcyc = rq; in_busy = bz;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'b111111, 6'b000000);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
    end
    total++;
    if (out_grant !== 6'b0 || out_grant_valid !== 1'b0 || out_owner !== 3'd0) begin
      bad++; $display("FAIL reset_outputs got grant=%b valid=%b owner=%0d want 0/0/0", out_grant, out_grant_valid, out_owner);
    end
  endtask

  task automatic test_single();
    logic [5:0] rq[10] = '{6'b1, 6'b1, 6'b1, 6'b1, 6'b1, 6'b1, 6'b0, 6'b0, 6'b0, 6'b000011};
    logic [5:0] bz[10] = '{6'b0, 6'b1, 6'b1, 6'b1, 6'b1, 6'b1, 6'b0, 6'b0, 6'b0, 6'b0};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, rq[i], bz[i]);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL single step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
      if (i == 0) begin
        total++;
        if (out_grant !== 6'b000001) begin bad++; $display("FAIL single_grant got=%b want=000001", out_grant); end
      end
    end
    total++;
    if (out_grant !== 6'b000010) begin bad++; $display("FAIL single_rrptr got=%b want=000010", out_grant); end
    for (int i = 0; i < 3; i++) step(1'b0, 6'b0, 6'b0);
  endtask

  task automatic test_priority();
    logic [5:0] rq[7] = '{6'b010001, 6'b010001, 6'b010001, 6'b000001, 6'b000001, 6'b000001, 6'b0};
    logic [5:0] bz[7] = '{6'b0, 6'b010000, 6'b010000, 6'b0, 6'b0, 6'b0, 6'b0};
    for (int i = 0; i < 7; i++) begin
      step(1'b0, rq[i], bz[i]);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL prio step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
      if (i == 0) begin
        total++;
        if (out_grant !== 6'b010000 || out_owner !== 3'd4) begin bad++; $display("FAIL prio_mm got=%b/%0d want=010000/4", out_grant, out_owner); end
      end
      if (i == 5) begin
        total++;
        if (out_grant !== 6'b000001) begin bad++; $display("FAIL prio_fetch got=%b want=000001", out_grant); end
      end
    end
    for (int i = 0; i < 2; i++) step(1'b0, 6'b0, 6'b0);
  endtask

  task automatic test_round_robin();
    int order[$];
    int starts[$];
    int bc = 0;
    logic [5:0] bz;
    bit prev = 0;
    for (int i = 0; i < 22; i++) begin
      bz = '0;
      if (m_owner < 0) bc = 0;
      else if (bc < 2) begin bz[m_owner] = 1'b1; bc++; end
      step(1'b0, 6'b111000, bz);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL rr step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
      if (out_grant_valid && !prev) begin order.push_back(int'(out_owner)); starts.push_back(i); end
      prev = out_grant_valid;
    end
    total++;
    if (order.size() < 4 || order[0] != 3 || order[1] != 4 || order[2] != 5 || order[3] != 3) begin
      bad++; $display("FAIL rr_order got=%p want 3,4,5,3", order);
    end else begin
      for (int k = 1; k < 4; k++) begin
        total++;
        if (starts[k] - starts[k-1] != 5) begin bad++; $display("FAIL rr_spacing got=%0d want=5", starts[k] - starts[k-1]); end
      end
    end
    while (m_owner >= 0 || m_cool) step(1'b0, 6'b0, 6'b0);
    step(1'b0, 6'b0, 6'b0);
  endtask

  task automatic test_timeout();
    int seen = -1;
    step(1'b0, 6'b000100, 6'b0);
    total++;
    if (out_grant !== 6'b000100) begin bad++; $display("FAIL to_grant got=%b want=000100", out_grant); end
    for (int i = 1; i <= 20 && seen < 0; i++) begin
      step(1'b0, 6'b000100, 6'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL to step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
      if (out_timeout_err) seen = i;
    end
    total++;
    if (seen != TO || out_grant !== 6'b0) begin bad++; $display("FAIL to_pulse got=%0d grant=%b want=%0d/000000", seen, out_grant, TO); end
    step(1'b0, 6'b0, 6'b0);
    total++;
    if (out_timeout_err !== 1'b0) begin bad++; $display("FAIL to_onecycle got=%b want=0", out_timeout_err); end
    step(1'b0, 6'b0, 6'b0);
    step(1'b0, 6'b101000, 6'b0);
    total++;
    if (out_grant !== 6'b001000) begin bad++; $display("FAIL to_rrptr got=%b want=001000", out_grant); end
    for (int i = 0; i < 3; i++) step(1'b0, 6'b0, 6'b0);
  endtask

  task automatic test_protocol();
    logic [5:0] bz[5] = '{6'b0, 6'b000010, 6'b100010, 6'b000010, 6'b0};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'b000010, bz[i]);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL perr step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
      if (i == 2) begin
        total++;
        if (out_protocol_err !== 1'b1 || out_grant !== 6'b000010) begin
          bad++; $display("FAIL perr_pulse got=%b/%b want=1/000010", out_protocol_err, out_grant);
        end
      end
    end
    for (int i = 0; i < 3; i++) step(1'b0, 6'b0, 6'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b0, 6'b010000, 6'b0);
    step(1'b0, 6'b010000, 6'b010000);
    step(1'b1, 6'b010000, 6'b010000);
    total++;
    if (out_grant !== 6'b0 || out_grant_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL rst_mid got=%b want=%b", dut_vec(), exp_vec());
    end
    step(1'b0, 6'b000100, 6'b0);
    total++;
    if (out_grant !== 6'b000100 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL rst_regrant got=%b want=%b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 3; i++) step(1'b0, 6'b0, 6'b0);
  endtask

  task automatic test_random();
    logic [5:0] rq = '0, bz;
    bit bmode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) rq = 6'($urandom);
      if ($urandom_range(31) == 0) bmode = ~bmode;
      bz = '0;
      if (m_owner >= 0 && bmode && $urandom_range(3) != 0) bz[m_owner] = 1'b1;
      if ($urandom_range(15) == 0) bz[$urandom_range(5)] = 1'b1;
      step($urandom_range(99) == 0, rq, bz);
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL random step%0d got=%b want=%b", i, dut_vec(), exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_timeout();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
